id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode pipeline stage of the 16-bit core.
- Accepts fetched instructions over a valid/ready handshake and decodes them into the 3-bit ALU command, register addresses, a sign-extended immediate and control flags.
- Holds a 1-bit-per-register pending-write scoreboard and stalls on RAW/WAW hazards.
- Sits between fetch and execute; execute drives the ALU with out_cmd.

Parameters:
- NREG, 8, number of architectural registers (register 0 reads as zero and is never pending)
- XLEN, 16, datapath, instruction and PC width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  16  instruction word
- in_pc  in  16  PC of in_instr
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts the bundle
- out_pc  out  16  registered in_pc
- out_cmd  out  3  ALU command: 000 add, 001 sub, 010 shl, 011 signed gt, 100 shr, 101 and, 110 or, 111 eq
- out_rd, out_rs, out_rt  out  3 each  register addresses
- out_imm  out  16  sign-extended imm6, or zero-extended imm12 for J
- out_use_imm, out_wb, out_mem_rd, out_mem_wr, out_branch, out_jump, out_illegal  out  1 each  control flags
- flush  in  1  branch/jump redirect from execute
- wb_valid  in  1  writeback retires a register write
- wb_rd  in  3  register being retired

Behaviour:
- Instruction fields: [15:12] opcode, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] funct, [5:0] imm6, [11:0] imm12.
- Decode, by opcode:
  - 0x0 R-type: cmd=funct; wb=1; sources rs, rt.
  - 0x1 ADDI: cmd=000; use_imm; wb=1; source rs.
  - 0x2 LW: cmd=000; use_imm; mem_rd; wb=1; source rs.
  - 0x3 SW: cmd=000; use_imm; mem_wr; wb=0; sources rs, rd (store data).
  - 0x4 BEQ: cmd=111; branch; use_imm; wb=0; sources rd, rs.
  - 0x5 J: jump; imm=zext(imm12); wb=0; no sources.
  - Any other opcode: illegal=1, all other flags 0, cmd=000, no sources, no scoreboard update.
- out_wb is forced to 0 when rd==0.
- Hazard: asserted when any used source, or the rd of a wb instruction, has its pending bit set. Pending bit 0 is always 0.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Accept (in_valid && in_ready): the output register loads the decode, and out_valid=1 on the next cycle. Latency is 1 cycle.
- No accept while out_ready=1: out_valid goes to 0 (bubble).
- Stall: out_valid && !out_ready holds every output stable.
- Scoreboard:
  - Set pending[rd] on accept with wb=1.
  - Clear pending[wb_rd] on wb_valid.
  - Same-cycle set and clear of the same register: the set wins. This is legal because WAW stalls guarantee the clear belongs to the older instruction.
  - wb_valid with wb_rd=0, or for a register that is not pending, is a no-op.
- Flush: the next cycle has out_valid=0. If the held bundle had wb=1, clear pending[out_rd], unless wb_valid retires the same register in that cycle (idempotent). No input is accepted during the flush cycle.
- Reset (async, rst_n=0): out_valid=0, all outputs 0, scoreboard all 0. Asserting rst_n mid-stall discards the held bundle.

Optional Feature:
- Macro ID_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 16 bits, reset 0.
  - Increments on each cycle with in_valid && hazard && !flush.
  - Saturates at 0xFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants (OP_RTYPE..OP_J)
  - ALU command constants (ALU_ADD..ALU_EQ), also used by the ALU
  - field bit-position constants
- Sub-module id_scoreboard: holds the NREG pending bits, set/clear/flush-clear ports and a combinational busy lookup for three addresses. Decode logic stays in id_stage.

Test Plan:
- Reset, then in_instr=0x0A4D (R-type, rd=5, rs=1, rt=1, funct=101) with out_ready=1 -> next cycle out_valid=1, out_cmd=101, out_rd=5, out_wb=1; pending[5]=1.
- ADDI rd=2, rs=1, imm6=0x3F -> out_imm=0xFFFF, out_use_imm=1, out_cmd=000.
- RAW: write r3, then an instruction reading r3 with no writeback -> in_ready=0 until wb_valid with wb_rd=3; accepted the cycle after the clear. With ID_STALL_CNT_EN, stall_cnt equals the stall cycle count.
- Backpressure: out_ready=0 for 4 cycles with a valid bundle -> outputs stable and in_ready=0; releasing out_ready accepts the next instruction in the same cycle.
- Flush with a held LW rd=4 -> out_valid=0 the next cycle, pending[4]=0, no instruction accepted during the flush cycle.
- Illegal opcode 0xE000 -> out_illegal=1, out_wb=0, scoreboard unchanged. Writes to r0 -> out_wb=0 and pending[0] stays 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core: opcodes, ALU commands and
// instruction field positions. Used by decode and by the ALU.
package core_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_J     = 4'h5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SHL = 3'b010;
  localparam logic [2:0] ALU_SGT = 3'b011;
  localparam logic [2:0] ALU_SHR = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int RD_HI    = 11;
  localparam int RD_LO    = 9;
  localparam int RS_HI    = 8;
  localparam int RS_LO    = 6;
  localparam int RT_HI    = 5;
  localparam int RT_LO    = 3;
  localparam int FN_HI    = 2;
  localparam int FN_LO    = 0;
  localparam int IMM6_HI  = 5;
  localparam int IMM12_HI = 11;

endpackage

// File: rtl/id_scoreboard.sv
// Pending-write scoreboard: one bit per register, register 0 never pending.
// A set on the same register as a clear in the same cycle wins.
module id_scoreboard #(
  parameter int NREG = 8,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic          fclr_en,
  input  logic [AW-1:0] fclr_addr,
  input  logic [AW-1:0] look_a,
  input  logic [AW-1:0] look_b,
  input  logic [AW-1:0] look_c,
  output logic          busy_a,
  output logic          busy_b,
  output logic          busy_c
);

  logic [NREG-1:0] pending_reg;
  logic [NREG-1:0] pending_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign pending_next[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;
        assign set_hit = set_en && (set_addr == AW'(gi));
        assign clr_hit = (clr_en && (clr_addr == AW'(gi))) ||
                         (fclr_en && (fclr_addr == AW'(gi)));
        assign pending_next[gi] = set_hit || (pending_reg[gi] && !clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign busy_a = pending_reg[look_a];
  assign busy_b = pending_reg[look_b];
  assign busy_c = pending_reg[look_c];

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage with RAW/WAW hazard stalls and a one-deep output
// register. Optional stall counter output enabled by ID_STALL_CNT_EN.
module id_stage
  import core_pkg::*;
#(
  parameter int NREG = 8,
  parameter int XLEN = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_cmd,
  output logic [2:0]      out_rd,
  output logic [2:0]      out_rs,
  output logic [2:0]      out_rt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_use_imm,
  output logic            out_wb,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal,
  input  logic            flush,
  input  logic            wb_valid,
  input  logic [2:0]      wb_rd
`ifdef ID_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [2:0]      cmd;
    logic [2:0]      rd;
    logic [2:0]      rs;
    logic [2:0]      rt;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            wb;
    logic            mem_rd;
    logic            mem_wr;
    logic            branch;
    logic            jump;
    logic            illegal;
  } bundle_t;

  bundle_t    dec_next;
  bundle_t    bundle_reg;
  logic       out_valid_reg;
  logic [3:0] opcode;
  logic       use_rs, use_rt, use_rd;
  logic       busy_rs, busy_rt, busy_rd;
  logic       hazard;
  logic       accept;

  assign opcode = in_instr[OP_HI:OP_LO];

  always_comb begin
    dec_next         = '0;
    dec_next.pc      = in_pc;
    dec_next.rd      = in_instr[RD_HI:RD_LO];
    dec_next.rs      = in_instr[RS_HI:RS_LO];
    dec_next.rt      = in_instr[RT_HI:RT_LO];
    dec_next.cmd     = ALU_ADD;
    dec_next.imm     = {{(XLEN-6){in_instr[IMM6_HI]}}, in_instr[IMM6_HI:0]};
    use_rs           = 1'b0;
    use_rt           = 1'b0;
    use_rd           = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_next.cmd = in_instr[FN_HI:FN_LO];
        dec_next.wb  = 1'b1;
        use_rs       = 1'b1;
        use_rt       = 1'b1;
      end
      OP_ADDI: begin
        dec_next.use_imm = 1'b1;
        dec_next.wb      = 1'b1;
        use_rs           = 1'b1;
      end
      OP_LW: begin
        dec_next.use_imm = 1'b1;
        dec_next.mem_rd  = 1'b1;
        dec_next.wb      = 1'b1;
        use_rs           = 1'b1;
      end
      OP_SW: begin
        dec_next.use_imm = 1'b1;
        dec_next.mem_wr  = 1'b1;
        use_rs           = 1'b1;
        use_rd           = 1'b1;
      end
      OP_BEQ: begin
        dec_next.cmd     = ALU_EQ;
        dec_next.branch  = 1'b1;
        dec_next.use_imm = 1'b1;
        use_rs           = 1'b1;
        use_rd           = 1'b1;
      end
      OP_J: begin
        dec_next.jump = 1'b1;
        dec_next.imm  = {{(XLEN-12){1'b0}}, in_instr[IMM12_HI:0]};
      end
      default: begin
        dec_next.illegal = 1'b1;
        dec_next.imm     = '0;
      end
    endcase
    if (dec_next.rd == 3'd0) begin
      dec_next.wb = 1'b0;
    end
  end

  // rd is looked up both as a store/branch source and for WAW on writers
  id_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (accept && dec_next.wb),
    .set_addr  (dec_next.rd),
    .clr_en    (wb_valid),
    .clr_addr  (wb_rd),
    .fclr_en   (flush && out_valid_reg && bundle_reg.wb),
    .fclr_addr (bundle_reg.rd),
    .look_a    (dec_next.rs),
    .look_b    (dec_next.rt),
    .look_c    (dec_next.rd),
    .busy_a    (busy_rs),
    .busy_b    (busy_rt),
    .busy_c    (busy_rd)
  );

  assign hazard   = (use_rs && busy_rs) || (use_rt && busy_rt) ||
                    ((use_rd || dec_next.wb) && busy_rd);
  assign in_ready = (!out_valid_reg || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      bundle_reg    <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      bundle_reg    <= dec_next;
    end else if (out_ready || flush) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_pc      = bundle_reg.pc;
  assign out_cmd     = bundle_reg.cmd;
  assign out_rd      = bundle_reg.rd;
  assign out_rs      = bundle_reg.rs;
  assign out_rt      = bundle_reg.rt;
  assign out_imm     = bundle_reg.imm;
  assign out_use_imm = bundle_reg.use_imm;
  assign out_wb      = bundle_reg.wb;
  assign out_mem_rd  = bundle_reg.mem_rd;
  assign out_mem_wr  = bundle_reg.mem_wr;
  assign out_branch  = bundle_reg.branch;
  assign out_jump    = bundle_reg.jump;
  assign out_illegal = bundle_reg.illegal;

`ifdef ID_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (in_valid && hazard && !flush && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Randomized self-checking bench for id_stage against a behavioural model
// of decode, the pending-write set and the output handshake.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic [15:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_pc;
  logic [2:0]  out_cmd, out_rd, out_rs, out_rt;
  logic [15:0] out_imm;
  logic        out_use_imm, out_wb, out_mem_rd, out_mem_wr;
  logic        out_branch, out_jump, out_illegal;
  logic        flush = 1'b0;
  logic        wb_valid = 1'b0;
  logic [2:0]  wb_rd = '0;
`ifdef ID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_cmd(out_cmd), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_imm(out_imm), .out_use_imm(out_use_imm), .out_wb(out_wb),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_branch(out_branch),
    .out_jump(out_jump), .out_illegal(out_illegal),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd)
`ifdef ID_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [2:0]  cmd, rd, rs, rt;
    logic [15:0] imm;
    logic        use_imm, wb, mem_rd, mem_wr, branch, jump, illegal;
    logic [7:0]  src;
  } exp_t;

  int   n_tests = 0;
  int   n_fail = 0;
  logic [7:0] m_pend = '0;
  logic       m_valid = 1'b0;
  exp_t       m_b = '0;
  int         m_stall = 0;
  logic       last_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_decode(input logic [15:0] instr, input logic [15:0] pc);
    exp_t e;
    e     = '0;
    e.pc  = pc;
    e.rd  = instr[11:9];
    e.rs  = instr[8:6];
    e.rt  = instr[5:3];
    e.imm = 16'($signed(instr[5:0]));
    case (instr[15:12])
      4'h0: begin e.cmd = instr[2:0]; e.wb = 1; e.src = (8'd1 << e.rs) | (8'd1 << e.rt); end
      4'h1: begin e.use_imm = 1; e.wb = 1; e.src = 8'd1 << e.rs; end
      4'h2: begin e.use_imm = 1; e.mem_rd = 1; e.wb = 1; e.src = 8'd1 << e.rs; end
      4'h3: begin e.use_imm = 1; e.mem_wr = 1; e.src = (8'd1 << e.rs) | (8'd1 << e.rd); end
      4'h4: begin e.cmd = 3'd7; e.branch = 1; e.use_imm = 1; e.src = (8'd1 << e.rs) | (8'd1 << e.rd); end
      4'h5: begin e.jump = 1; e.imm = {4'h0, instr[11:0]}; end
      default: begin e.illegal = 1; e.imm = '0; end
    endcase
    if (e.rd == 3'd0) e.wb = 0;
    return e;
  endfunction

  function automatic logic model_hazard(input exp_t e);
    logic [7:0] need;
    need = e.src | (e.wb ? (8'd1 << e.rd) : 8'd0);
    return |(need & m_pend);
  endfunction

  task automatic check_outputs();
    check("out_valid", out_valid, m_valid);
    check("out_pc", out_pc, m_b.pc);
    check("out_cmd", out_cmd, m_b.cmd);
    check("out_rd", out_rd, m_b.rd);
    check("out_rs", out_rs, m_b.rs);
    check("out_rt", out_rt, m_b.rt);
    check("out_imm", out_imm, m_b.imm);
    check("out_flags", {out_use_imm, out_wb, out_mem_rd, out_mem_wr, out_branch, out_jump, out_illegal},
          {m_b.use_imm, m_b.wb, m_b.mem_rd, m_b.mem_wr, m_b.branch, m_b.jump, m_b.illegal});
`ifdef ID_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  task automatic cycle(input logic iv, input logic [15:0] instr, input logic [15:0] pc,
                       input logic ordy, input logic fl, input logic wbv, input logic [2:0] wbrd);
    exp_t d;
    logic hz, exp_rdy, acc;
    logic [7:0] p;
    @(negedge clk);
    in_valid = iv; in_instr = instr; in_pc = pc; out_ready = ordy;
    flush = fl; wb_valid = wbv; wb_rd = wbrd;
    #1;
    d = model_decode(instr, pc);
    hz = model_hazard(d);
    exp_rdy = (!m_valid || ordy) && !hz && !fl;
    check("in_ready", in_ready, exp_rdy);
    last_ready = in_ready;
    acc = iv && exp_rdy;
    @(posedge clk);
    p = m_pend;
    if (wbv) p[wbrd] = 1'b0;
    if (fl && m_valid && m_b.wb) p[m_b.rd] = 1'b0;
    if (acc && d.wb) p[d.rd] = 1'b1;
    p[0] = 1'b0;
    m_pend = p;
    if (iv && hz && !fl && m_stall < 16'hFFFF) m_stall++;
    if (acc) begin
      m_b = d;
      m_valid = 1'b1;
      $display("[TB] accept pc=0x%04h instr=0x%04h", pc, instr);
    end else if (ordy || fl) begin
      m_valid = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    m_pend = '0; m_valid = 1'b0; m_b = '0; m_stall = 0;
  endtask

  initial begin
    int stalls;
    logic [3:0] op;
    logic [15:0] instr;

    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check_outputs();
    rst_n = 1'b1;

    // R-type AND rd=5; then a reader of r5 must stall
    cycle(1, 16'h0A4D, 16'h0100, 1, 0, 0, 0);
    check("rtype_cmd", out_cmd, 3'b101);
    check("rtype_rd", out_rd, 5);
    check("rtype_wb", out_wb, 1);
    cycle(1, 16'h1140, 16'h0102, 1, 0, 0, 0);
    check("pend5_stall", last_ready, 0);

    cycle(1, 16'h147F, 16'h0104, 1, 0, 0, 0);
    check("addi_imm", out_imm, 16'hFFFF);
    check("addi_use_imm", out_use_imm, 1);
    check("addi_cmd", out_cmd, 0);

    // RAW on r3: three stalls, clear cycle, accept the cycle after
    cycle(1, 16'h1600, 16'h0200, 1, 0, 0, 0);
    stalls = 0;
    repeat (3) begin
      cycle(1, 16'h4600, 16'h0202, 1, 0, 0, 0);
      if (!last_ready) stalls++;
    end
    cycle(1, 16'h4600, 16'h0202, 1, 0, 1, 3);
    if (!last_ready) stalls++;
    cycle(1, 16'h4600, 16'h0202, 1, 0, 0, 0);
    check("raw_stalls", stalls, 4);
    check("raw_accept", last_ready, 1);

    // Backpressure for four cycles, release accepts in the same cycle
    cycle(1, 16'h1C05, 16'h0300, 1, 0, 0, 0);
    stalls = 0;
    repeat (4) begin
      cycle(1, 16'h0000, 16'h0302, 0, 0, 0, 0);
      if (!last_ready) stalls++;
    end
    check("bp_stalls", stalls, 4);
    check("bp_hold_pc", out_pc, 16'h0300);
    cycle(1, 16'h0000, 16'h0302, 1, 0, 0, 0);
    check("bp_release", last_ready, 1);

    // Flush a held LW r4
    cycle(1, 16'h2800, 16'h0400, 1, 0, 0, 0);
    cycle(1, 16'h0000, 16'h0402, 0, 0, 0, 0);
    cycle(1, 16'h0000, 16'h0402, 0, 1, 0, 0);
    check("flush_no_accept", last_ready, 0);
    check("flush_valid", out_valid, 0);
    cycle(1, 16'h1100, 16'h0404, 1, 0, 0, 0);
    check("flush_clr4", last_ready, 1);

    // Illegal opcode and writes to r0
    cycle(1, 16'hE000, 16'h0500, 1, 0, 0, 0);
    check("illegal_flag", out_illegal, 1);
    check("illegal_wb", out_wb, 0);
    cycle(1, 16'h1005, 16'h0502, 1, 0, 0, 0);
    check("r0_wb", out_wb, 0);
    cycle(1, 16'h0000, 16'h0504, 1, 0, 0, 0);
    check("r0_not_pending", last_ready, 1);

    for (int i = 0; i < 1500; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      instr = {op, 12'($urandom)};
      cycle(($urandom_range(0, 3) != 0), instr, 16'($urandom),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) < 3), 3'($urandom_range(0, 7)));
    end

    // Reset in the middle of a stall discards the held bundle and scoreboard
    for (int r = 1; r < 8; r++) cycle(0, 16'h0000, 16'h0000, 1, 0, 1, 3'(r));
    cycle(1, 16'h1200, 16'h0600, 1, 0, 0, 0);
    cycle(1, 16'h0000, 16'h0602, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_valid", out_valid, 0);
    check("midrst_pc", out_pc, 0);
    check("midrst_rd", out_rd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 16'h1040, 16'h0700, 1, 0, 0, 0);
    check("midrst_pend_clear", last_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
